// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache with 2-word blocks, LL/SC and halt flush.
// Define DCACHE_HITCNT_EN to add hit/miss counters and the final counter write to FLUSH_ADDR.
module dcache_wb #(
  parameter int          SETS       = 8,
  parameter logic [31:0] FLUSH_ADDR = 32'h3100
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic        datomic,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - IDX_W - 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS - 1);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] WB0       = 4'd1;
  localparam logic [3:0] WB1       = 4'd2;
  localparam logic [3:0] FETCH0    = 4'd3;
  localparam logic [3:0] FETCH1    = 4'd4;
  localparam logic [3:0] FLUSH_CHK = 4'd5;
  localparam logic [3:0] FLUSH_WB0 = 4'd6;
  localparam logic [3:0] FLUSH_WB1 = 4'd7;
`ifdef DCACHE_HITCNT_EN
  localparam logic [3:0] CNT_WR    = 4'd8;
`endif
  localparam logic [3:0] FLUSHED   = 4'd9;

  logic [3:0]       state;
  logic [SETS-1:0]  valid;
  logic [SETS-1:0]  dirty;
  logic [TAG_W-1:0] tags  [SETS];
  logic [31:0]      word0 [SETS];
  logic [31:0]      word1 [SETS];
  logic             link_valid;
  logic [29:0]      link_addr;
  logic [IDX_W-1:0] flush_idx;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             req_off;
  logic             hit;
  logic             link_match;
  logic             is_sc;
  logic             do_store;
  logic             miss;
  logic [3:0]       walk_done;

  assign req_idx    = dmemaddr[IDX_W+2:3];
  assign req_tag    = dmemaddr[31:IDX_W+3];
  assign req_off    = dmemaddr[2];
  assign hit        = valid[req_idx] && (tags[req_idx] == req_tag);
  assign link_match = link_valid && (link_addr == dmemaddr[31:2]);
  assign is_sc      = dmemWEN && datomic;

`ifdef DCACHE_HITCNT_EN
  logic [31:0] hits;
  logic [31:0] misses;
  logic        unused;
  assign walk_done = CNT_WR;
  assign unused    = &{1'b0, dmemaddr[1:0]};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hits   <= '0;
      misses <= '0;
    end else begin
      if (dhit) hits <= hits + 32'd1;
      if (miss) misses <= misses + 32'd1;
    end
  end
`else
  logic unused;
  assign walk_done = FLUSHED;
  assign unused    = &{1'b0, dmemaddr[1:0], FLUSH_ADDR};
`endif

  // A failed SC still completes as a hit, returning 0 without touching the line.
  always_comb begin
    dhit     = 1'b0;
    dmemload = '0;
    flushed  = 1'b0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = '0;
    dstore   = '0;
    do_store = 1'b0;
    miss     = 1'b0;
    case (state)
      IDLE: begin
        if (!halt) begin
          if (is_sc) begin
            dhit = 1'b1;
            if (hit && link_match) begin
              dmemload = 32'd1;
              do_store = 1'b1;
            end
          end else if (dmemREN || dmemWEN) begin
            if (hit) begin
              dhit = 1'b1;
              if (dmemREN) dmemload = req_off ? word1[req_idx] : word0[req_idx];
              if (dmemWEN) do_store = 1'b1;
            end else begin
              miss = 1'b1;
            end
          end
        end
      end
      WB0: begin
        dWEN   = 1'b1;
        daddr  = {tags[req_idx], req_idx, 1'b0, 2'b00};
        dstore = word0[req_idx];
      end
      WB1: begin
        dWEN   = 1'b1;
        daddr  = {tags[req_idx], req_idx, 1'b1, 2'b00};
        dstore = word1[req_idx];
      end
      FETCH0: begin
        dREN  = 1'b1;
        daddr = {req_tag, req_idx, 1'b0, 2'b00};
      end
      FETCH1: begin
        dREN  = 1'b1;
        daddr = {req_tag, req_idx, 1'b1, 2'b00};
      end
      FLUSH_WB0: begin
        dWEN   = 1'b1;
        daddr  = {tags[flush_idx], flush_idx, 1'b0, 2'b00};
        dstore = word0[flush_idx];
      end
      FLUSH_WB1: begin
        dWEN   = 1'b1;
        daddr  = {tags[flush_idx], flush_idx, 1'b1, 2'b00};
        dstore = word1[flush_idx];
      end
`ifdef DCACHE_HITCNT_EN
      CNT_WR: begin
        dWEN   = 1'b1;
        daddr  = FLUSH_ADDR;
        dstore = hits - misses;
      end
`endif
      FLUSHED: flushed = 1'b1;
      default: ;
    endcase
  end

  // The first fetched word lands in the line immediately; the tag and valid bit
  // only change once the second word arrives, so a reset mid-fill leaves nothing valid.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      valid      <= '0;
      dirty      <= '0;
      link_valid <= 1'b0;
      link_addr  <= '0;
      flush_idx  <= '0;
      for (int i = 0; i < SETS; i++) begin
        tags[i]  <= '0;
        word0[i] <= '0;
        word1[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (halt) begin
            state     <= FLUSH_CHK;
            flush_idx <= '0;
          end else if (do_store) begin
            if (req_off) word1[req_idx] <= dmemstore;
            else         word0[req_idx] <= dmemstore;
            dirty[req_idx] <= 1'b1;
            if (link_match) link_valid <= 1'b0;
          end else if (dhit && dmemREN && datomic) begin
            link_addr  <= dmemaddr[31:2];
            link_valid <= 1'b1;
          end else if (miss) begin
            state <= (valid[req_idx] && dirty[req_idx]) ? WB0 : FETCH0;
          end
        end
        WB0: if (!dwait) state <= WB1;
        WB1: if (!dwait) state <= FETCH0;
        FETCH0: begin
          if (!dwait) begin
            word0[req_idx] <= dload;
            state          <= FETCH1;
          end
        end
        FETCH1: begin
          if (!dwait) begin
            word1[req_idx] <= dload;
            tags[req_idx]  <= req_tag;
            valid[req_idx] <= 1'b1;
            dirty[req_idx] <= 1'b0;
            state          <= IDLE;
          end
        end
        FLUSH_CHK: begin
          if (valid[flush_idx] && dirty[flush_idx]) state <= FLUSH_WB0;
          else if (flush_idx == LAST_IDX) state <= walk_done;
          else flush_idx <= flush_idx + 1'b1;
        end
        FLUSH_WB0: if (!dwait) state <= FLUSH_WB1;
        FLUSH_WB1: begin
          if (!dwait) begin
            dirty[flush_idx] <= 1'b0;
            state            <= FLUSH_CHK;
          end
        end
`ifdef DCACHE_HITCNT_EN
        CNT_WR: if (!dwait) state <= FLUSHED;
`endif
        FLUSHED: state <= FLUSHED;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_wb.sv
// Bench for dcache_wb: vector table checked against a flat reference memory, plus
// a memory model that checks every bus transfer against a queue of expected ones.
module tb_dcache_wb;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        halt;
  logic        dmemREN;
  logic        dmemWEN;
  logic        datomic;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;

  always #5 CLK = ~CLK;

  dcache_wb #(.SETS(8), .FLUSH_ADDR(32'h3100)) dut (
    .CLK(CLK), .nRST(nRST), .halt(halt),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .datomic(datomic),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait)
  );

  typedef struct {
    logic        ren;
    logic        wen;
    logic        atomic;
    logic [31:0] addr;
    logic [31:0] data;
    logic        sc_ok;
    logic        miss;
    logic [31:0] wb_base;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  int          n_vec = 0;
  int          n_miscmp = 0;
  int          n_writes = 0;
  int          lat = 2;
  int          wait_cnt;
  int          hits_exp = 0;
  int          miss_exp = 0;
  bit          mem_ready = 1'b0;
  xfer_t       wq[$];
  logic [31:0] rq[$];
  logic [31:0] mem     [0:4095];
  logic [31:0] ref_mem [0:4095];
  vec_t        vecs    [19];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[13:2]);
  endfunction

  function automatic vec_t mk(input logic ren, input logic wen, input logic atomic,
                              input logic [31:0] addr, input logic [31:0] data,
                              input logic sc_ok, input logic miss, input logic [31:0] wb_base);
    vec_t v;
    v.ren = ren; v.wen = wen; v.atomic = atomic; v.addr = addr; v.data = data;
    v.sc_ok = sc_ok; v.miss = miss; v.wb_base = wb_base;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic push_wr(input logic [31:0] a);
    xfer_t x;
    x.addr = a;
    x.data = ref_mem[widx(a)];
    wq.push_back(x);
  endtask

  // Memory: dwait stays high for 'lat' cycles of each transfer.
  assign dwait = (dREN || dWEN) && (wait_cnt < lat);
  assign dload = mem[daddr[13:2]];

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) wait_cnt <= 0;
    else if (dwait) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  always @(posedge CLK) begin : mem_model
    xfer_t x;
    logic [31:0] ra;
    if (!mem_ready) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_val(32'(i) << 2);
      mem_ready <= 1'b1;
    end else if (nRST && !dwait && (dREN || dWEN)) begin
      if (dWEN) begin
        n_writes++;
        if (wq.size() == 0) begin
          n_vec++;
          n_miscmp++;
          $display("[TB] FAIL unexpected_write: got %h at %h, expected no write", dstore, daddr);
        end else begin
          x = wq.pop_front();
          checkOutput("wr_addr", daddr, x.addr);
          checkOutput("wr_data", dstore, x.data);
        end
        mem[daddr[13:2]] <= dstore;
      end
      if (dREN) begin
        if (rq.size() == 0) begin
          n_vec++;
          n_miscmp++;
          $display("[TB] FAIL unexpected_read: got %h, expected no read", daddr);
        end else begin
          ra = rq.pop_front();
          checkOutput("rd_addr", daddr, ra);
        end
      end
    end
  end

  task automatic applyStimulus(input vec_t v);
    int          cycles;
    logic [31:0] base;
    logic [31:0] got;
    base = v.addr & ~32'h7;
    if (v.wb_base != 32'h0) begin
      push_wr(v.wb_base);
      push_wr(v.wb_base + 32'h4);
    end
    if (v.miss) begin
      rq.push_back(base);
      rq.push_back(base + 32'h4);
    end
    @(negedge CLK);
    dmemREN   = v.ren;
    dmemWEN   = v.wen;
    datomic   = v.atomic;
    dmemaddr  = v.addr;
    dmemstore = v.data;
    cycles    = 0;
    #1;
    while (!dhit && cycles < 200) begin
      @(negedge CLK);
      #1;
      cycles++;
    end
    checkOutput("dhit", 32'(dhit), 32'd1);
    got = dmemload;
    checkOutput("miss", 32'(cycles > 0), 32'(v.miss));
    if (v.ren) checkOutput("load", got, ref_mem[widx(v.addr)]);
    else if (v.atomic) checkOutput("sc_result", got, 32'(v.sc_ok));
    @(posedge CLK);
    #1;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
    datomic = 1'b0;
    if (v.wen && (!v.atomic || v.sc_ok)) ref_mem[widx(v.addr)] = v.data;
    hits_exp++;
    if (v.miss) miss_exp++;
    checkOutput("xfer_pending", 32'(wq.size() + rq.size()), 32'd0);
  endtask

  initial begin
    int cycles;
    int w0;
    int n_flush;
    nRST = 1'b0; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0;
    dmemaddr = '0; dmemstore = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(32'(i) << 2);

    vecs[0]  = mk(1, 0, 0, 32'h40,  32'h0,        0, 1, 32'h0);
    vecs[1]  = mk(1, 0, 0, 32'h44,  32'h0,        0, 0, 32'h0);
    vecs[2]  = mk(0, 1, 0, 32'h40,  32'hDEADBEEF, 0, 0, 32'h0);
    vecs[3]  = mk(1, 0, 0, 32'h80,  32'h0,        0, 1, 32'h40);
    vecs[4]  = mk(1, 0, 1, 32'h100, 32'h0,        0, 1, 32'h0);
    vecs[5]  = mk(0, 1, 1, 32'h100, 32'h5,        1, 0, 32'h0);
    vecs[6]  = mk(1, 0, 0, 32'h100, 32'h0,        0, 0, 32'h0);
    vecs[7]  = mk(0, 1, 1, 32'h100, 32'h7,        0, 0, 32'h0);
    vecs[8]  = mk(1, 0, 0, 32'h100, 32'h0,        0, 0, 32'h0);
    vecs[9]  = mk(1, 0, 1, 32'h100, 32'h0,        0, 0, 32'h0);
    vecs[10] = mk(0, 1, 0, 32'h100, 32'h9,        0, 0, 32'h0);
    vecs[11] = mk(0, 1, 1, 32'h100, 32'hB,        0, 0, 32'h0);
    vecs[12] = mk(1, 0, 0, 32'h100, 32'h0,        0, 0, 32'h0);
    vecs[13] = mk(0, 1, 1, 32'h200, 32'h33,       0, 0, 32'h0);
    vecs[14] = mk(1, 0, 0, 32'h104, 32'h0,        0, 0, 32'h0);
    vecs[15] = mk(0, 1, 0, 32'h50,  32'h22,       0, 1, 32'h0);
    vecs[16] = mk(0, 1, 0, 32'h168, 32'h55,       0, 1, 32'h0);
    vecs[17] = mk(0, 1, 0, 32'h16C, 32'h66,       0, 0, 32'h0);
    vecs[18] = mk(1, 0, 0, 32'h300, 32'h0,        0, 1, 32'h100);

    repeat (2) @(negedge CLK);
    #1;
    checkOutput("rst_dhit",     32'(dhit),    32'd0);
    checkOutput("rst_dmemload", dmemload,     32'd0);
    checkOutput("rst_flushed",  32'(flushed), 32'd0);
    checkOutput("rst_dREN",     32'(dREN),    32'd0);
    checkOutput("rst_dWEN",     32'(dWEN),    32'd0);
    checkOutput("rst_daddr",    daddr,        32'd0);
    checkOutput("rst_dstore",   dstore,       32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < 19; i++) applyStimulus(vecs[i]);

    // Flush: dirty lines remain at index 2 and index 5 only.
    lat = 1;
    push_wr(32'h50);
    push_wr(32'h54);
    push_wr(32'h168);
    push_wr(32'h16C);
    n_flush = 4;
`ifdef DCACHE_HITCNT_EN
    begin
      xfer_t c;
      c.addr = 32'h3100;
      c.data = 32'(hits_exp - miss_exp);
      wq.push_back(c);
      n_flush = 5;
    end
`endif
    w0 = n_writes;
    @(negedge CLK);
    halt = 1'b1;
    cycles = 0;
    #1;
    while (!flushed && cycles < 500) begin
      @(negedge CLK);
      #1;
      cycles++;
    end
    checkOutput("flushed", 32'(flushed), 32'd1);
    checkOutput("flush_writes", 32'(n_writes - w0), 32'(n_flush));
    checkOutput("flush_pending", 32'(wq.size()), 32'd0);

    halt = 1'b0;
    repeat (4) @(negedge CLK);
    #1;
    checkOutput("flushed_held", 32'(flushed), 32'd1);
    checkOutput("flushed_idle_bus", 32'(dREN || dWEN), 32'd0);

    nRST = 1'b0;
    #1;
    checkOutput("rst2_flushed", 32'(flushed), 32'd0);
    checkOutput("rst2_bus", 32'(dREN || dWEN), 32'd0);
    wq.delete();
    rq.delete();
    @(negedge CLK);
    nRST = 1'b1;
    lat = 2;

    // Reset while the second word of a fill is outstanding.
    rq.push_back(32'h40);
    rq.push_back(32'h44);
    @(negedge CLK);
    dmemREN  = 1'b1;
    dmemaddr = 32'h40;
    cycles   = 0;
    #1;
    while (!(dREN && daddr == 32'h44) && cycles < 50) begin
      @(negedge CLK);
      #1;
      cycles++;
    end
    checkOutput("fetch1_reached", 32'(dREN && daddr == 32'h44), 32'd1);
    nRST = 1'b0;
    #1;
    checkOutput("rst_mid_dREN", 32'(dREN), 32'd0);
    dmemREN = 1'b0;
    rq.delete();
    @(negedge CLK);
    nRST = 1'b1;
    applyStimulus(mk(1, 0, 0, 32'h44, 32'h0, 0, 1, 32'h0));
    applyStimulus(mk(1, 0, 0, 32'h40, 32'h0, 0, 0, 32'h0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/dcache_wb.md
Name: dcache_wb

Overview:
- Data-cache responder for the cache side of the datapath/cache interface; serves the pipeline's MEM-stage loads, stores and LL/SC.
- Direct-mapped, write-back, write-allocate, 2-word blocks.
- Sits between the datapath's dmem* request signals and the memory controller's d* port.
- On processor halt, flushes all dirty lines to memory, then raises flushed.

Parameters:
SETS, 8, number of lines; power of 2, at least 2; IDX_W = log2(SETS)
FLUSH_ADDR, 32'h3100, address written by the optional hit-count store

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
halt  in  1  datapath halted; starts the flush
dmemREN  in  1  load request
dmemWEN  in  1  store request
datomic  in  1  request is LL (with REN) or SC (with WEN)
dmemaddr  in  32  word address; bits [1:0] ignored
dmemstore  in  32  store data
dhit  out  1  request completed this cycle
dmemload  out  32  load data, or SC result
flushed  out  1  flush complete
dREN  out  1  memory read
dWEN  out  1  memory write
daddr  out  32  memory word address
dstore  out  32  memory write data
dload  in  32  memory read data
dwait  in  1  memory busy; a transfer completes in a cycle where dREN|dWEN is high and dwait is low

Behaviour:
- Address fields:
  - tag = [31:IDX_W+3]
  - index = [IDX_W+2:3]
  - block offset = [2]
- Per-line state: valid, dirty, tag, word0, word1. All cleared on reset.
- Reset values: dhit=0, dmemload=0, flushed=0, dREN=0, dWEN=0, daddr=0, dstore=0, link_valid=0, state=IDLE.
- Reset mid-operation aborts any transfer immediately.
- IDLE:
  - Hit = valid && tag match; dhit is combinational in the same cycle.
  - Load hit: dmemload = selected word.
  - Store hit: the word is written at the clock edge; the dirty bit is set.
  - dhit is high for exactly the cycles the request is held on a hit. The datapath drops the request after dhit.
  - Miss on a dirty line -> WB0. Miss on a clean line -> FETCH0.
  - REN and WEN together is illegal and is not checked.
- WB0 / WB1:
  - dWEN=1, daddr = {old tag, index, 0/1, 2'b00}, dstore = word0/word1.
  - Advance on !dwait. WB1 -> FETCH0.
- FETCH0 / FETCH1:
  - dREN=1, daddr = {req tag, index, 0/1, 2'b00}.
  - On !dwait, capture dload into word0/word1.
  - FETCH1 -> IDLE with valid=1, dirty=0, new tag. The request then hits on the next cycle.
- LL/SC (single link register):
  - LL hit: load as normal; link_addr = dmemaddr[31:2]; link_valid=1.
  - SC hit with link_valid and a matching address: store performed, dmemload = 1, link_valid cleared.
  - SC otherwise: no store, dmemload = 0, dhit=1 with no fill. An SC miss completes immediately with failure.
  - Any successful store to link_addr clears link_valid.
- Flush:
  - Applies when halt is high in IDLE with no pending miss; requests are no longer served.
  - FLUSH_CHK walks index 0..SETS-1 using a counter. Valid&&dirty lines go to FLUSH_WB0/FLUSH_WB1, each advancing on !dwait. Those lines are then marked clean.
  - After the last index: go to FLUSHED (via CNT_WR when the option is enabled).
- FLUSHED: flushed=1, memory outputs idle. Held until reset. halt deasserting is ignored.
- The miss counter does not wrap within a program. The hit counter is 32 bits and wraps modulo 2^32.

Optional Feature:
- Macro DCACHE_HITCNT_EN.
- Defined:
  - 32-bit hit counter: +1 per IDLE cycle with dhit, including a failed SC.
  - 32-bit miss counter: +1 per transition out of IDLE to WB0 or FETCH0.
  - After the flush walk, state CNT_WR writes dWEN, daddr=FLUSH_ADDR, dstore=hits-misses; on !dwait go to FLUSHED.
- Undefined: no counters, no CNT_WR; FLUSH_CHK goes directly to FLUSHED.

Test Plan:
- Reset, load 0x40 with dwait low after 2 cycles -> FETCH0 reads 0x40 and FETCH1 reads 0x44; dhit next IDLE cycle, dmemload=dload value; load 0x44 -> hit in 0 cycles.
- Store 0xDEADBEEF to 0x40, then load 0x80 (same index, SETS=8) -> WB0/WB1 write 0x40/0x44 with 0xDEADBEEF and old word1, then fetch 0x80/0x84.
- LL 0x100, SC 0x100 with data 5 -> dmemload=1, word updated; a second SC 0x100 -> dmemload=0, memory unchanged.
- LL 0x100, plain store 0x100, SC 0x100 -> dmemload=0.
- Two dirty lines at indices 2 and 5, assert halt -> exactly 4 dWEN transfers in index order, then flushed=1 permanently; with DCACHE_HITCNT_EN, a fifth write to 0x3100 of hits-misses.
- Assert nRST during FETCH1 -> dREN drops immediately, all lines invalid, the next load misses.
